// File: rtl/cla_accum_sched.sv
// cla_accum_sched: round-robin scheduler sharing one 20-bit carry-lookahead
// adder among NUM_REQ partial-sum requesters. A granted lane streams LEN
// signed 19-bit beats. Each beat is added into a 19-bit accumulator that
// saturates after every add. The result is returned over a valid/ready port.
//
// Ports
//   clk_i, rst_ni        clock, async active-low reset
//   req_i                per-lane request (level)
//   len_i                per-lane beat count, sampled at grant
//   grant_o              one-hot adder owner during ACCUM and DONE
//   data_valid_i/data_i  per-lane beat stream
//   data_ready_o         per-lane beat ready; only the owner, only in ACCUM
//   res_*                result handshake: sum, lane id, sticky saturation
//   busy_o               FSM not idle
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrate among req_i starting at rr_ptr
// ACCUM | owner lane streams beats through the shared adder
// DONE  | result presented, held until res_ready_i

// 20-bit adder built from five 4-bit lookahead groups. The group carries
// ripple from one group to the next.
module cla_20b (
    input  logic [19:0] a_i,
    input  logic [19:0] b_i,
    input  logic        cin_i,
    output logic [19:0] sum_o,
    output logic        overflow_o
);
    logic [19:0] w_g;
    logic [19:0] w_p;
    logic [20:0] w_c;

    assign w_g = a_i & b_i;
    assign w_p = a_i ^ b_i;

    always_comb begin
        logic [20:0] c;
        c    = '0;
        c[0] = cin_i;
        for (int k = 0; k < 5; k++) begin
            c[4*k+1] = w_g[4*k] | (w_p[4*k] & c[4*k]);
            c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                     | (w_p[4*k+1] & w_p[4*k] & c[4*k]);
            c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                     | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                     | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & c[4*k]);
            c[4*k+4] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                     | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                     | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                     | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & c[4*k]);
        end
        w_c = c;
    end

    assign sum_o      = w_p ^ w_c[19:0];
    assign overflow_o = w_c[20] ^ w_c[19];
endmodule

module cla_accum_sched #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ*LEN_W-1:0]     len_i,
    output logic [NUM_REQ-1:0]           grant_o,
    input  logic [NUM_REQ-1:0]           data_valid_i,
    input  logic [NUM_REQ*19-1:0]        data_i,
    output logic [NUM_REQ-1:0]           data_ready_o,
    output logic                         res_valid_o,
    input  logic                         res_ready_i,
    output logic [18:0]                  res_data_o,
    output logic [$clog2(NUM_REQ)-1:0]   res_id_o,
    output logic                         res_sat_o,
    output logic                         busy_o
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int DW   = 19;
    localparam logic [DW-1:0] ACC_MAX = 19'h3FFFF;   //  262143
    localparam logic [DW-1:0] ACC_MIN = 19'h40000;   // -262144

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [DW-1:0]     r_acc;
    logic              r_sat;

    logic [LEN_W-1:0]  w_len_lane  [NUM_REQ];
    logic [DW-1:0]     w_data_lane [NUM_REQ];
    logic              w_pick_valid;
    logic [ID_W-1:0]   w_pick_id;
    logic              w_beat;
    logic              w_last;
    logic [DW-1:0]     w_beat_data;
    logic [19:0]       w_sum;
    logic              w_unused_ovf;
    logic              w_pos_ovf;
    logic              w_neg_ovf;
    logic [DW-1:0]     w_acc_sat;
    logic [NUM_REQ-1:0] w_onehot;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        assign w_len_lane[k]  = len_i[k*LEN_W +: LEN_W];
        assign w_data_lane[k] = data_i[k*DW +: DW];
    end

    // First requesting lane at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_l;
        w_pick_valid = 1'b0;
        w_pick_id    = '0;
        idx          = 0;
        idx_l        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_l = ID_W'(idx);
            if (!w_pick_valid && req_i[idx_l]) begin
                w_pick_valid = 1'b1;
                w_pick_id    = idx_l;
            end
        end
    end

    assign w_beat      = (r_state == ST_ACCUM) && data_valid_i[r_id];
    assign w_last      = (r_cnt == r_len - LEN_W'(1));
    assign w_beat_data = w_data_lane[r_id];
    assign w_onehot    = NUM_REQ'(1) << r_id;

    cla_20b u_cla (
        .a_i        ({r_acc[DW-1], r_acc}),
        .b_i        ({w_beat_data[DW-1], w_beat_data}),
        .cin_i      (1'b0),
        .sum_o      (w_sum),
        .overflow_o (w_unused_ovf)
    );

    // Sign-extended 19-bit operands always fit in 20 bits, so the 19-bit
    // range is exceeded exactly when the top two sum bits disagree.
    assign w_pos_ovf = ~w_sum[19] &  w_sum[18];
    assign w_neg_ovf =  w_sum[19] & ~w_sum[18];
    assign w_acc_sat = w_pos_ovf ? ACC_MAX :
                       w_neg_ovf ? ACC_MIN : w_sum[DW-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        grant_o      = '0;
        data_ready_o = '0;
        res_valid_o  = 1'b0;
        res_data_o   = '0;
        res_id_o     = '0;
        res_sat_o    = 1'b0;
        busy_o       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = (w_len_lane[w_pick_id] != '0) ? ST_ACCUM : ST_DONE;
                end
            end
            ST_ACCUM: begin
                busy_o       = 1'b1;
                grant_o      = w_onehot;
                data_ready_o = w_onehot;
                if (w_beat && w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy_o      = 1'b1;
                grant_o     = w_onehot;
                res_valid_o = 1'b1;
                res_data_o  = r_acc;
                res_id_o    = r_id;
                res_sat_o   = r_sat;
                // Return through IDLE so the next grant starts from the
                // advanced pointer.
                if (res_ready_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_id     <= '0;
            r_rr_ptr <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_sat    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_id  <= w_pick_id;
                        r_len <= w_len_lane[w_pick_id];
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_sat <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (w_beat) begin
                        r_acc <= w_acc_sat;
                        r_sat <= r_sat | w_pos_ovf | w_neg_ovf;
                        r_cnt <= r_cnt + LEN_W'(1);
                    end
                end
                ST_DONE: begin
                    if (res_ready_i) begin
                        r_rr_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
